// File: rtl/kronos_dmem_responder.sv
// Core data-bus responder: word RAM with byte lanes plus LED/switch/hex MMIO; DMEM_ERR_EN adds data_err.
// Ack follows req by 1+WAIT_STATES cycles; the core holds req until ack and a new request is taken only in IDLE.
module kronos_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  input  logic [9:0]  sw_in,
  output logic [9:0]  led_out,
  output logic [23:0] hex_out
`ifdef DMEM_ERR_EN
  ,
  output logic        data_err
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [29:0] LED_WA    = MMIO_BASE[31:2];
  localparam logic [29:0] SW_WA     = LED_WA + 30'd1;
  localparam logic [29:0] HEX_WA    = LED_WA + 30'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    mask_q;
  logic          wr_q;
  logic [31:0]   rd_q;
  logic [9:0]    led_q;
  logic [23:0]   hex_q;
  logic [9:0]    sw_meta_q, sw_sync_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, commit, ram_we;
  logic [31:0]   cur_addr, cur_wdata;
  logic [3:0]    cur_mask;
  logic          cur_wr;
  logic          in_ram, is_led, is_sw, is_hex;
  logic [AW-1:0] ram_idx;
  logic [31:0]   rd_word;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACK: begin
        data_ack = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE) && data_req;
  assign commit = (state_d == S_ACK) && (state_q != S_ACK);

  // With no wait states the access commits on its accept edge, before the latches hold it.
  assign cur_addr  = accept ? data_addr    : addr_q;
  assign cur_wdata = accept ? data_wr_data : wdata_q;
  assign cur_mask  = accept ? data_mask    : mask_q;
  assign cur_wr    = accept ? data_wr_en   : wr_q;

  assign in_ram  = cur_addr < RAM_BYTES;
  assign is_led  = cur_addr[31:2] == LED_WA;
  assign is_sw   = cur_addr[31:2] == SW_WA;
  assign is_hex  = cur_addr[31:2] == HEX_WA;
  assign ram_idx = cur_addr[AW+1:2];

  always_comb begin
    rd_word = 32'h0;
    if (in_ram)      rd_word = mem[ram_idx];
    else if (is_led) rd_word = {22'h0, led_q};
    else if (is_sw)  rd_word = {22'h0, sw_sync_q};
    else if (is_hex) rd_word = {8'h0, hex_q};
  end

  // Gated by rstz so a request held through reset can never land in RAM.
  assign ram_we = commit && cur_wr && in_ram && rstz;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_mask[i]) mem[ram_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      mask_q    <= 4'h0;
      wr_q      <= 1'b0;
      rd_q      <= 32'h0;
      led_q     <= 10'h0;
      hex_q     <= 24'h0;
      sw_meta_q <= 10'h0;
      sw_sync_q <= 10'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      if (accept) begin
        addr_q  <= data_addr;
        wdata_q <= data_wr_data;
        mask_q  <= data_mask;
        wr_q    <= data_wr_en;
      end
      if (commit) begin
        if (!cur_wr) begin
          rd_q <= rd_word;
        end else if (is_led) begin
          if (cur_mask[0]) led_q[7:0] <= cur_wdata[7:0];
          if (cur_mask[1]) led_q[9:8] <= cur_wdata[9:8];
        end else if (is_hex) begin
          if (cur_mask[0]) hex_q[7:0]   <= cur_wdata[7:0];
          if (cur_mask[1]) hex_q[15:8]  <= cur_wdata[15:8];
          if (cur_mask[2]) hex_q[23:16] <= cur_wdata[23:16];
        end
      end
    end
  end

`ifdef DMEM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) err_q <= 1'b0;
    else       err_q <= commit && (!(in_ram || is_led || is_sw || is_hex) || (is_sw && cur_wr));
  end

  assign data_err = err_q;
`endif

  assign data_rd_data = rd_q;
  assign led_out      = led_q;
  assign hex_out      = hex_q;

endmodule

// File: tb/tb_kronos_dmem_responder.sv
// Bench for kronos_dmem_responder: a zero-wait instance (d0) and a three-wait instance (d3) against a region-level model.
module tb_kronos_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;
  logic        wr_en;
  logic        req0, req3;
  logic        ack0, ack3;
  logic [31:0] rd0, rd3;
  logic [9:0]  sw;
  logic [9:0]  led0, led3;
  logic [23:0] hex0, hex3;
`ifdef DMEM_ERR_EN
  logic        err0, err3;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [int];
  logic [9:0]  led_m [2];
  logic [23:0] hex_m [2];
  logic [31:0] rd_m  [2];

  always #5 clk = ~clk;

  kronos_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .MMIO_BASE(BASE)) d0 (
    .clk(clk), .rstz(rstz), .data_addr(addr), .data_wr_data(wdata), .data_mask(mask),
    .data_wr_en(wr_en), .data_req(req0), .data_ack(ack0), .data_rd_data(rd0),
    .sw_in(sw), .led_out(led0), .hex_out(hex0)
`ifdef DMEM_ERR_EN
    , .data_err(err0)
`endif
  );

  kronos_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .MMIO_BASE(BASE)) d3 (
    .clk(clk), .rstz(rstz), .data_addr(addr), .data_wr_data(wdata), .data_mask(mask),
    .data_wr_en(wr_en), .data_req(req3), .data_ack(ack3), .data_rd_data(rd3),
    .sw_in(sw), .led_out(led3), .hex_out(hex3)
`ifdef DMEM_ERR_EN
    , .data_err(err3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ackof(input int s);
    return (s != 0) ? ack3 : ack0;
  endfunction
  function automatic logic [31:0] rdof(input int s);
    return (s != 0) ? rd3 : rd0;
  endfunction
  function automatic logic [31:0] ledof(input int s);
    return (s != 0) ? {22'h0, led3} : {22'h0, led0};
  endfunction
  function automatic logic [31:0] hexof(input int s);
    return (s != 0) ? {8'h0, hex3} : {8'h0, hex0};
  endfunction
  function automatic logic errof(input int s);
`ifdef DMEM_ERR_EN
    return (s != 0) ? err3 : err0;
`else
    return (s != 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic set_req(input int s, input logic v);
    if (s != 0) req3 = v;
    else        req0 = v;
  endtask

  // 0 RAM, 1 LED, 2 SW, 3 HEX, 4 unmapped
  function automatic int region(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (a < 32'd4096)   return 0;
    if (w == BASE)      return 1;
    if (w == BASE + 4)  return 2;
    if (w == BASE + 8)  return 3;
    return 4;
  endfunction

  function automatic int key(input int s, input logic [31:0] a);
    return s * 2048 + int'(a >> 2);
  endfunction

  function automatic logic [31:0] model_read(input int s, input logic [31:0] a);
    case (region(a))
      0:       return mem_m.exists(key(s, a)) ? mem_m[key(s, a)] : 32'hx;
      1:       return {22'h0, led_m[s]};
      2:       return {22'h0, sw};
      3:       return {8'h0, hex_m[s]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] old;
    case (region(a))
      0: begin
        old = mem_m.exists(key(s, a)) ? mem_m[key(s, a)] : 32'hx;
        for (int i = 0; i < 4; i++) if (m[i]) old[8*i +: 8] = d[8*i +: 8];
        mem_m[key(s, a)] = old;
      end
      1: begin
        if (m[0]) led_m[s][7:0] = d[7:0];
        if (m[1]) led_m[s][9:8] = d[9:8];
      end
      3: begin
        if (m[0]) hex_m[s][7:0]   = d[7:0];
        if (m[1]) hex_m[s][15:8]  = d[15:8];
        if (m[2]) hex_m[s][23:16] = d[23:16];
      end
      default: ;
    endcase
  endtask

  // Starts and ends on a falling edge with the responder idle.
  task automatic do_access(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input logic w, input bit drop, output logic [31:0] rdat, output logic err,
                           output int lat);
    bit got;
    got = 0;
    addr = a; wdata = d; mask = m; wr_en = w;
    set_req(s, 1'b1);
    lat = 0; rdat = 32'h0; err = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ackof(s)) begin
        got = 1; rdat = rdof(s); err = errof(s);
      end else begin
        addr = $urandom; wdata = $urandom; mask = 4'($urandom); wr_en = 1'($urandom);
        if (drop) set_req(s, 1'b0);
      end
    end
    set_req(s, 1'b0);
    if (!got) check("ack_timeout", {31'h0, got}, 32'd1);
    @(negedge clk);
    check("ack_pulse", {31'h0, ackof(s)}, 32'd0);
  endtask

  task automatic access(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic w, input bit drop, output logic [31:0] rdat);
    logic [31:0] exp;
    logic        e;
    int          lat;
    exp = model_read(s, a);
    do_access(s, a, d, m, w, drop, rdat, e, lat);
    check("latency", 32'(lat), (s != 0) ? 32'd4 : 32'd1);
    if (!w) begin
      check("rd_data", rdat, exp);
      rd_m[s] = exp;
    end else begin
      check("rd_hold", rdat, rd_m[s]);
      model_write(s, a, d, m);
    end
    check("led_out", ledof(s), {22'h0, led_m[s]});
    check("hex_out", hexof(s), {8'h0, hex_m[s]});
`ifdef DMEM_ERR_EN
    check("data_err", {31'h0, e}, {31'h0, (region(a) == 4) || (region(a) == 2 && w)});
`else
    if (e) check("data_err_absent", {31'h0, e}, 32'd0);
`endif
  endtask

  task automatic reset_models;
    for (int s = 0; s < 2; s++) begin
      led_m[s] = 10'h0; hex_m[s] = 24'h0; rd_m[s] = 32'h0;
    end
  endtask

  initial begin
    logic [31:0] r;
    rstz = 1'b0; req0 = 1'b0; req3 = 1'b0;
    addr = 32'h0; wdata = 32'h0; mask = 4'h0; wr_en = 1'b0; sw = 10'h0;
    reset_models();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ack", {31'h0, ackof(s)}, 32'd0);
      check("rst_led", ledof(s), 32'h0);
      check("rst_hex", hexof(s), 32'h0);
      check("rst_rd",  rdof(s), 32'h0);
    end
    rstz = 1'b1;
    @(negedge clk);

    // Byte lanes and latency on both instances.
    for (int s = 0; s < 2; s++) begin
      access(s, 32'h10, 32'h1122_3344, 4'b1111, 1'b1, 1'b0, r);
      access(s, 32'h10, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, r);
      access(s, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0, r);
      check("bytelane_lit", r, 32'h11BB_33DD);
      access(s, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0, r);
      access(s, 32'h12, 32'h0, 4'b1111, 1'b0, 1'b0, r);
    end

    // MMIO window.
    sw = 10'h2A5;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      access(s, BASE, 32'h0000_03FF, 4'b1111, 1'b1, 1'b0, r);
      check("led_lit", ledof(s), 32'h3FF);
      access(s, BASE + 4, 32'h0, 4'b1111, 1'b0, 1'b0, r);
      check("sw_lit", r, 32'h0000_02A5);
      access(s, BASE + 8, 32'h0012_3456, 4'b1111, 1'b1, 1'b0, r);
      check("hex_lit", hexof(s), 32'h0012_3456);
      access(s, BASE + 4, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, r);
      access(s, BASE, 32'hFFFF_FC00, 4'b0010, 1'b1, 1'b0, r);
    end

    // Unmapped space aliases nothing.
    for (int s = 0; s < 2; s++) begin
      access(s, 32'h0, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0, r);
      access(s, 32'h0000_8000, 32'h0, 4'b1111, 1'b0, 1'b0, r);
      check("unmapped_rd", r, 32'h0);
      access(s, 32'h0000_8000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, r);
      access(s, 32'h0, 32'h0, 4'b1111, 1'b0, 1'b0, r);
      check("unmapped_alias", r, 32'hCAFE_F00D);
    end

    // Randomized traffic over a small initialized working set.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        access(s, 32'h100 + 32'(4 * i), $urandom, 4'b1111, 1'b1, 1'b0, r);
    for (int n = 0; n < 80; n++) begin
      int          s, kind;
      logic [31:0] a;
      bit          drop;
      s    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      if (kind <= 5)      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      else if (kind == 6) a = BASE;
      else if (kind == 7) a = BASE + 4;
      else if (kind == 8) a = BASE + 8;
      else                a = ($urandom_range(0, 1) != 0) ? BASE + 32'hC : 32'hFFFF_FFF0;
      a    = a | 32'($urandom_range(0, 3));
      drop = (s == 1) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        sw = 10'($urandom);
        repeat (3) @(negedge clk);
      end
      access(s, a, $urandom, 4'($urandom), 1'($urandom), drop, r);
    end

    // Reset during a pending write on the wait-state instance.
    access(1, 32'h20, 32'h0BAD_F00D, 4'b1111, 1'b1, 1'b0, r);
    addr = 32'h20; wdata = 32'hDEAD_BEEF; mask = 4'b1111; wr_en = 1'b1; req3 = 1'b1;
    @(negedge clk);
    check("abort_c1", {31'h0, ack3}, 32'd0);
    @(negedge clk);
    rstz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_noack", {31'h0, ack3}, 32'd0);
    end
    req3 = 1'b0;
    rstz = 1'b1;
    reset_models();
    check("abort_led", ledof(1), 32'h0);
    check("abort_hex", hexof(1), 32'h0);
    check("abort_rd",  rdof(1), 32'h0);
    @(negedge clk);
    check("abort_idle", {31'h0, ack3}, 32'd0);
    access(1, 32'h20, 32'h0, 4'b1111, 1'b0, 1'b0, r);
    check("abort_keep", r, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
